// File: rtl/mac_vec_sequencer_if.sv
// mac_vec_sequencer_if
// Bundle between the vector sequencer, its operand source and result sink, and
// the external combinational MAC (d = (a*b)[W-1:0] + c).
//   control : start, vec_len, busy
//   operand : in_valid, in_ready, in_a, in_b
//   MAC     : mac_a, mac_b, mac_c (to MAC), mac_d (from MAC, same cycle)
//   result  : out_valid, out_ready, out_result
// master = sequencer side, slave = environment (fetch logic, MAC, consumer).
interface mac_vec_sequencer_if #(
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int LEN_BITWIDTH       = 8
);
    logic                          start;
    logic [LEN_BITWIDTH-1:0]       vec_len;
    logic                          busy;
    logic                          in_valid;
    logic                          in_ready;
    logic [DATA_PATH_BITWIDTH-1:0] in_a;
    logic [DATA_PATH_BITWIDTH-1:0] in_b;
    logic [DATA_PATH_BITWIDTH-1:0] mac_a;
    logic [DATA_PATH_BITWIDTH-1:0] mac_b;
    logic [DATA_PATH_BITWIDTH-1:0] mac_c;
    logic [DATA_PATH_BITWIDTH-1:0] mac_d;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_PATH_BITWIDTH-1:0] out_result;

    modport master (
        input  start, vec_len, in_valid, in_a, in_b, mac_d, out_ready,
        output busy, in_ready, mac_a, mac_b, mac_c, out_valid, out_result
    );

    modport slave (
        output start, vec_len, in_valid, in_a, in_b, mac_d, out_ready,
        input  busy, in_ready, mac_a, mac_b, mac_c, out_valid, out_result
    );
endinterface

// File: rtl/mac_vec_sequencer.sv
// mac_vec_sequencer
// Streams operand pairs into an external no-flop MAC, feeding mac_d back as the
// running accumulator, and hands the final dot product out over valid/ready.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mac_vec_sequencer_if.master (control, operand, MAC and result groups)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; MAC a/b held at zero
// S_ACCUM | accepting operand pairs, acc <- mac_d on every beat
// S_DONE  | result_q presented on out_result until out_ready
module mac_vec_sequencer #(
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int LEN_BITWIDTH       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    mac_vec_sequencer_if.master    bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                        r_state;
    logic [DATA_PATH_BITWIDTH-1:0] r_acc;
    logic [DATA_PATH_BITWIDTH-1:0] r_result;
    logic [LEN_BITWIDTH-1:0]       r_cnt;
    logic [LEN_BITWIDTH-1:0]       r_len;
    logic                          r_in_ready;
    logic                          r_out_valid;
    logic                          r_busy;

    logic                          w_beat;
    logic                          w_last;

    assign w_beat = bus.in_valid & r_in_ready;
    // r_len is never zero in S_ACCUM, so len-1 cannot underflow; cnt reaches
    // at most len, which fits even for the maximum length.
    assign w_last = (r_cnt == (r_len - LEN_BITWIDTH'(1)));

    // No-flop path to the MAC: operands pass straight through while accepting.
    assign bus.mac_a      = r_in_ready ? bus.in_a : '0;
    assign bus.mac_b      = r_in_ready ? bus.in_b : '0;
    assign bus.mac_c      = r_acc;
    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_result;
    assign bus.busy       = r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_busy <= 1'b1;
                        if (bus.vec_len != '0) begin
                            r_state    <= S_ACCUM;
                            r_len      <= bus.vec_len;
                            r_cnt      <= '0;
                            r_acc      <= '0;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state     <= S_DONE;
                            r_result    <= '0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_beat) begin
                        r_acc <= bus.mac_d;
                        r_cnt <= r_cnt + LEN_BITWIDTH'(1);
                        if (w_last) begin
                            r_result    <= bus.mac_d;
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_acc       <= '0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mac_vec_sequencer.sv
module tb_mac_vec_sequencer;
    localparam int DW = 16;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_vec_sequencer_if #(.DATA_PATH_BITWIDTH(DW), .LEN_BITWIDTH(LW)) bus ();

    mac_vec_sequencer #(.DATA_PATH_BITWIDTH(DW), .LEN_BITWIDTH(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External combinational MAC.
    logic [2*DW-1:0] mac_prod;
    assign mac_prod  = bus.mac_a * bus.mac_b;
    assign bus.mac_d = mac_prod[DW-1:0] + bus.mac_c;

    int n_vec = 0;
    int n_mis = 0;

    // ---------------- behavioural reference ----------------
    // phase: 0 waiting, 1 collecting pairs, 2 holding result
    int          m_phase  = 0;
    int          m_left   = 0;
    logic [DW-1:0] m_sum  = '0;
    logic [DW-1:0] m_res  = '0;
    logic [2*DW-1:0] m_p;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_sum = '0; m_res = '0; m_left = 0;
        end else begin
            case (m_phase)
                0: if (bus.start) begin
                    if (bus.vec_len == 0) begin
                        m_phase = 2; m_res = '0;
                    end else begin
                        m_phase = 1; m_left = int'(bus.vec_len); m_sum = '0;
                    end
                end
                1: if (bus.in_valid) begin
                    m_p    = bus.in_a * bus.in_b;
                    m_sum  = m_sum + m_p[DW-1:0];
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_res = m_sum; m_phase = 2;
                    end
                end
                default: if (bus.out_ready) begin
                    m_phase = 0; m_sum = '0;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare + monitors ----------------
    bit            chk_en = 1'b0;
    int            xfers  = 0;
    logic [DW-1:0] last_res = '0;
    logic [DW-1:0] macc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",   32'(bus.in_ready),   32'(m_phase == 1));
            chk("out_valid",  32'(bus.out_valid),  32'(m_phase == 2));
            chk("busy",       32'(bus.busy),       32'(m_phase != 0));
            chk("out_result", 32'(bus.out_result), 32'(m_res));
            chk("mac_c",      32'(bus.mac_c),      32'(m_sum));
            chk("mac_a",      32'(bus.mac_a),      (m_phase == 1) ? 32'(bus.in_a) : 32'd0);
            chk("mac_b",      32'(bus.mac_b),      (m_phase == 1) ? 32'(bus.in_b) : 32'd0);
            if (bus.in_valid && bus.in_ready) macc_q.push_back(bus.mac_c);
            if (bus.out_valid && bus.out_ready) begin
                xfers++;
                last_res = bus.out_result;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [LW-1:0] len);
        bus.start = 1'b1; bus.vec_len = len;
        cyc();
        bus.start = 1'b0; bus.vec_len = '0;
    endtask

    task automatic beat(input logic [DW-1:0] a, input logic [DW-1:0] b, input int gap);
        bit rdy;
        bit done = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
        for (int i = 0; i < 20 && !done; i++) begin
            rdy = bus.in_ready;
            cyc();
            if (rdy) done = 1'b1;
        end
        if (!done) begin
            n_vec++; n_mis++;
            $display("FAIL beat_accept: in_ready stayed %0b, required 1", bus.in_ready);
        end
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
        cyc(gap);
    endtask

    task automatic take_result(input int stall);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.out_valid) seen = 1'b1;
            else cyc();
        end
        if (!seen) begin
            n_vec++; n_mis++;
            $display("FAIL out_valid_wait: out_valid %0b, required 1", bus.out_valid);
        end
        cyc(stall);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        cyc();
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int x0;
        bus.start = 1'b0; bus.vec_len = '0; bus.in_valid = 1'b0;
        bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        cyc(2);
        chk_en = 1'b1;
        rst = 1'b0;
        cyc();
        chk("reset_out_result", 32'(bus.out_result), 32'd0);

        // Basic: 2*3+4*5+6*7 = 68, mac_c per beat 0,6,26
        macc_q.delete();
        x0 = xfers;
        do_start(8'd3);
        beat(16'd2, 16'd3, 0);
        beat(16'd4, 16'd5, 0);
        beat(16'd6, 16'd7, 0);
        chk("basic_latency_valid", 32'(bus.out_valid), 32'd1);
        take_result(0);
        chk("basic_result", 32'(last_res), 32'd68);
        chk("basic_beats", 32'(macc_q.size()), 32'd3);
        if (macc_q.size() == 3) begin
            chk("basic_macc0", 32'(macc_q[0]), 32'd0);
            chk("basic_macc1", 32'(macc_q[1]), 32'd6);
            chk("basic_macc2", 32'(macc_q[2]), 32'd26);
        end
        chk("basic_xfers", 32'(xfers - x0), 32'd1);

        // Wrap
        macc_q.delete();
        do_start(8'd2);
        beat(16'hFFFF, 16'hFFFF, 0);
        beat(16'h0100, 16'h0100, 0);
        take_result(0);
        chk("wrap_first_d", 32'(macc_q.size() > 1 ? macc_q[1] : 16'hDEAD), 32'h0001);
        chk("wrap_result", 32'(last_res), 32'h0001);
        do_start(8'd1);
        beat(16'h8000, 16'd2, 0);
        take_result(0);
        chk("wrap_result2", 32'(last_res), 32'h0000);

        // Stalls and backpressure: 3*4 + 5*6 = 42
        x0 = xfers;
        do_start(8'd2);
        cyc(2);
        beat(16'd3, 16'd4, 3);
        beat(16'd5, 16'd6, 0);
        take_result(4);
        chk("stall_result", 32'(last_res), 32'd42);
        chk("stall_xfers", 32'(xfers - x0), 32'd1);

        // Zero length
        do_start(8'd0);
        chk("zero_valid", 32'(bus.out_valid), 32'd1);
        chk("zero_in_ready", 32'(bus.in_ready), 32'd0);
        take_result(1);
        chk("zero_result", 32'(last_res), 32'd0);

        // Reset mid-vector, then fresh 3*3
        do_start(8'd4);
        beat(16'd10, 16'd10, 0);
        beat(16'd7, 16'd7, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_mac_c", 32'(bus.mac_c), 32'd0);
        do_start(8'd1);
        beat(16'd3, 16'd3, 0);
        take_result(0);
        chk("rst_result", 32'(last_res), 32'd9);

        // start ignored during ACCUM
        do_start(8'd2);
        bus.start = 1'b1; bus.vec_len = 8'd5;
        beat(16'd1, 16'd1, 0);
        bus.start = 1'b0; bus.vec_len = '0;
        beat(16'd1, 16'd1, 0);
        chk("ign_valid", 32'(bus.out_valid), 32'd1);
        take_result(0);
        chk("ign_result", 32'(last_res), 32'd2);
        chk("ign_idle", 32'(bus.busy), 32'd0);

        // Max length: 255 pairs of (1,1) -> 255
        do_start(8'd255);
        bus.in_valid = 1'b1; bus.in_a = 16'd1; bus.in_b = 16'd1;
        cyc(255);
        bus.in_valid = 1'b0;
        take_result(0);
        chk("maxlen_result", 32'(last_res), 32'd255);

        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
